hazard_unit: RTL
================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter RegAddrWidth, default 5, register address width.
REQ-002 Parameter MdTimeout, default 40, max cycles a mul/div op may stay outstanding.
REQ-003 Parameter PerfWidth, default 16, stall-counter width.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  in  1  clock, all state updates on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 ID_RS1, ID_RS2  in  RegAddrWidth each  decode-stage source registers.
REQ-008 ID_Uses_RS1, ID_Uses_RS2  in  1 each  decode instruction reads that source.
REQ-009 ID_RD, ID_Reg_File_EN  in  RegAddrWidth, 1  decode-stage destination and write enable.
REQ-010 ID_Is_MulDiv  in  1  decode instruction is multi-cycle M-extension op.
REQ-011 EX_RD, EX_Reg_File_EN, EX_Mem_Read_EN  in  RegAddrWidth, 1, 1  execute-stage destination, write enable, load flag.
REQ-012 EX_MulDiv_Start  in  1  M-unit accepts op in EX this cycle.
REQ-013 MulDiv_Done  in  1  single-cycle pulse, M-unit result presented to writeback.
REQ-014 Flush  in  1  branch/jump redirect, kills IF/ID/EX contents.
REQ-015 Stall_IF, Stall_ID, Bubble_EX  out  1 each  hold PC, hold IF/ID, insert NOP into EX.
REQ-016 MD_Busy, MD_RD  out  1, RegAddrWidth  outstanding mul/div and its destination.
REQ-017 MD_Timeout  out  1  sticky error flag.
REQ-018 Stall_Count  out  PerfWidth  cycles with Stall_ID asserted.

Function
REQ-019 Load-use hazard: EX_Mem_Read_EN & EX_Reg_File_EN & EX_RD!=0 & EX_RD equals an ID source in use -> assert Stall_IF, Stall_ID, Bubble_EX combinationally, exactly one cycle per load.
REQ-020 FSM states IDLE, MD_BUSY; IDLE->MD_BUSY on EX_MulDiv_Start & !Flush, latching EX_RD into MD_RD.
REQ-021 MD_BUSY->IDLE on the cycle after MulDiv_Done; MD_Busy/MD_RD cleared then.
REQ-022 In MD_BUSY, stall (Stall_IF, Stall_ID, Bubble_EX) when ID uses a source equal to MD_RD (RAW), ID_Reg_File_EN & ID_RD==MD_RD (WAW), or ID_Is_MulDiv (structural).
REQ-023 MD_RD==0 never produces RAW/WAW stalls; structural stall still applies.
REQ-024 Stall conditions also hold during the MulDiv_Done cycle; released next cycle, operand then supplied by writeback forwarding.
REQ-025 Flush overrides all stall outputs to 0 that cycle; Flush does not cancel an already-accepted mul/div (MD_BUSY retained).
REQ-026 Timeout counter counts cycles in MD_BUSY, cleared on entry; on reaching MdTimeout set MD_Timeout (sticky until rst), force IDLE, clear MD_Busy.
REQ-027 MulDiv_Done in IDLE is ignored; EX_MulDiv_Start in MD_BUSY is a protocol error, ignored (no state change).
REQ-028 Stall_Count increments when Stall_ID=1, saturates at all-ones.
REQ-029 Stall outputs are purely combinational from inputs and current state; no added latency.

Reset
REQ-030 On rst: state IDLE, MD_Busy=0, MD_RD=0, MD_Timeout=0, timeout counter=0, Stall_Count=0; stall outputs then follow REQ-019 only.
REQ-031 rst during MD_BUSY abandons the outstanding op; later MulDiv_Done ignored per REQ-027.

Structure
REQ-032 Shared package holds hazard FSM state enum and RegAddrWidth constant, reused by forwarding and decode.
REQ-033 One sub-module natural: md_scoreboard (FSM, MD_RD latch, timeout counter); load-use and stall logic in top.

Verification
REQ-034 EX load x5, ID add reads x5 -> Stall_IF/Stall_ID/Bubble_EX=1 for one cycle, then 0.
REQ-035 EX load x0, ID reads x0 -> no stall.
REQ-036 Start div to x7; ID reads x7 for 10 cycles; Done at cycle 10 -> stall through Done cycle, released cycle 11, MD_Busy=0.
REQ-037 MD_BUSY on x7, ID writes x7 (WAW) or issues mul -> stall; ID reads x8 -> no stall.
REQ-038 Start mul, no Done for 40 cycles -> MD_Timeout=1 at cycle 40, state IDLE, flag holds until rst.
REQ-039 Stall cycle coincident with Flush -> stall outputs 0; MD_Busy unchanged; Stall_Count not incremented.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// Shared hazard-detection definitions: FSM state encoding and register-address width,
// also imported by the forwarding and decode blocks.
package hazard_unit_pkg;

  localparam int unsigned REG_ADDR_WIDTH = 5;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_MD_BUSY = 1'b1
  } hz_state_e;

endpackage

// File: rtl/md_scoreboard.sv
// Tracks one outstanding multi-cycle mul/div op: busy flag, destination register,
// and a watchdog that abandons the op and raises a sticky error after MdTimeout cycles.
module md_scoreboard
  import hazard_unit_pkg::*;
#(
  parameter int unsigned RegAddrWidth = REG_ADDR_WIDTH,
  parameter int unsigned MdTimeout    = 40
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [RegAddrWidth-1:0] ex_rd,
  input  logic                    ex_muldiv_start,
  input  logic                    muldiv_done,
  input  logic                    flush,
  output logic                    md_busy,
  output logic [RegAddrWidth-1:0] md_rd,
  output logic                    md_timeout
);

  localparam int unsigned CntWidth = (MdTimeout > 1) ? $clog2(MdTimeout) : 1;
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(MdTimeout - 1);

  hz_state_e               state_q, state_d;
  logic [CntWidth-1:0]     cnt_q, cnt_d;
  logic [RegAddrWidth-1:0] rd_q, rd_d;
  logic                    to_q, to_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    to_d    = to_q;
    case (state_q)
      ST_IDLE: begin
        // A done pulse here belongs to no op we track and is ignored.
        if (ex_muldiv_start && !flush) begin
          state_d = ST_MD_BUSY;
          rd_d    = ex_rd;
          cnt_d   = '0;
        end
      end
      ST_MD_BUSY: begin
        // Completion wins over a watchdog expiry landing in the same cycle.
        if (muldiv_done) begin
          state_d = ST_IDLE;
          rd_d    = '0;
        end else if (cnt_q == CntLast) begin
          state_d = ST_IDLE;
          rd_d    = '0;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        rd_d    = '0;
      end
    endcase
  end

  assign md_busy    = (state_q == ST_MD_BUSY);
  assign md_rd      = rd_q;
  assign md_timeout = to_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use detection, mul/div RAW/WAW/structural interlock,
// flush override and a saturating stall-cycle counter.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int unsigned RegAddrWidth = REG_ADDR_WIDTH,
  parameter int unsigned MdTimeout    = 40,
  parameter int unsigned PerfWidth    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [RegAddrWidth-1:0] ID_RS1,
  input  logic [RegAddrWidth-1:0] ID_RS2,
  input  logic                    ID_Uses_RS1,
  input  logic                    ID_Uses_RS2,
  input  logic [RegAddrWidth-1:0] ID_RD,
  input  logic                    ID_Reg_File_EN,
  input  logic                    ID_Is_MulDiv,
  input  logic [RegAddrWidth-1:0] EX_RD,
  input  logic                    EX_Reg_File_EN,
  input  logic                    EX_Mem_Read_EN,
  input  logic                    EX_MulDiv_Start,
  input  logic                    MulDiv_Done,
  input  logic                    Flush,
  output logic                    Stall_IF,
  output logic                    Stall_ID,
  output logic                    Bubble_EX,
  output logic                    MD_Busy,
  output logic [RegAddrWidth-1:0] MD_RD,
  output logic                    MD_Timeout,
  output logic [PerfWidth-1:0]    Stall_Count
);

  logic load_use;
  logic md_raw;
  logic md_waw;
  logic md_hazard;
  logic stall;

  md_scoreboard #(
    .RegAddrWidth(RegAddrWidth),
    .MdTimeout   (MdTimeout)
  ) u_md_scoreboard (
    .clk            (clk),
    .rst            (rst),
    .ex_rd          (EX_RD),
    .ex_muldiv_start(EX_MulDiv_Start),
    .muldiv_done    (MulDiv_Done),
    .flush          (Flush),
    .md_busy        (MD_Busy),
    .md_rd          (MD_RD),
    .md_timeout     (MD_Timeout)
  );

  always_comb begin
    load_use = EX_Mem_Read_EN && EX_Reg_File_EN && (EX_RD != '0) &&
               ((ID_Uses_RS1 && (ID_RS1 == EX_RD)) ||
                (ID_Uses_RS2 && (ID_RS2 == EX_RD)));
    md_raw   = (ID_Uses_RS1 && (ID_RS1 == MD_RD)) ||
               (ID_Uses_RS2 && (ID_RS2 == MD_RD));
    md_waw   = ID_Reg_File_EN && (ID_RD == MD_RD);
    // x0 is never a real dependency, but a second mul/div still needs the unit.
    md_hazard = MD_Busy && (((MD_RD != '0) && (md_raw || md_waw)) || ID_Is_MulDiv);
    stall     = (load_use || md_hazard) && !Flush;
  end

  assign Stall_IF  = stall;
  assign Stall_ID  = stall;
  assign Bubble_EX = stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      Stall_Count <= '0;
    end else if (stall && (Stall_Count != '1)) begin
      Stall_Count <= Stall_Count + 1'b1;
    end
  end

endmodule
